// File: rtl/uart_pkg.sv
// Shared UART constants and helpers, used by both the transmitter and the receiver
// so the two ends of a loopback pair agree on frame timing.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   function automatic int bit_cycles(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   function automatic int frame_bits(input int data_bits, input int parity_en, input int stop_bits);
      return 1 + data_bits + parity_en + stop_bits;
   endfunction

   // Unused upper bits of a narrow character are zero, so they do not disturb the XOR.
   function automatic logic parity_bit(input logic [7:0] data, input logic odd);
      logic p;
      p = odd;
      for (int i = 0; i < 8; i++) begin
         p = p ^ data[i];
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_transmitter_baud.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and flags the last count and the one before it.
module uart_baud_tick #(
   parameter int BIT_CYCLES = 5208
) (
   input  logic clk_fpga,
   input  logic reset,
   input  logic clear,
   output logic tick,
   output logic pre_tick
);

   localparam int CNT_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(BIT_CYCLES - 2);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: wraps at BIT_CYCLES-1 rather than at a power of two.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (cnt_q == LAST_CNT) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_fpga) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick     = (cnt_q == LAST_CNT);
   assign pre_tick = (cnt_q == PRE_CNT);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits. Accepts one character per frame over valid/ready.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk_fpga,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 txd,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE);
   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
   localparam logic       HAS_PAR   = (PARITY_EN != 0);
   localparam logic       ODD_PAR   = (PARITY_ODD != 0);

   if (BIT_CYCLES < 2) begin : g_bad_baud
      $error("uart_transmitter: CLK_FREQ/BAUD_RATE must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_transmitter: DATA_BITS must be 5..8");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_transmitter: STOP_BITS must be 1 or 2");
   end

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 parity_q, parity_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic                 txd_q, txd_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 accept_s;
   logic                 tick_s;
   logic                 pre_tick_s;

   assign tx_ready = (state_q == IDLE) && !reset;
   assign accept_s = tx_valid && tx_ready;

   // Holding the timer clear while idle aligns the start bit to the accept edge.
   uart_baud_tick #(
      .BIT_CYCLES(BIT_CYCLES)
   ) u_baud (
      .clk_fpga (clk_fpga),
      .reset    (reset),
      .clear    (state_q == IDLE),
      .tick     (tick_s),
      .pre_tick (pre_tick_s)
   );

   // Frame sequencing; txd_d is the line level for the following clock.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      bit_cnt_d = bit_cnt_q;
      txd_d     = txd_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d   = START;
               shift_d   = tx_data;
               parity_d  = parity_bit(8'(tx_data), ODD_PAR);
               bit_cnt_d = 3'd0;
               txd_d     = 1'b0;
            end else begin
               txd_d     = 1'b1;
            end
         end
         START: begin
            if (tick_s) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
               txd_d     = shift_q[0];
            end else begin
               txd_d     = 1'b0;
            end
         end
         DATA: begin
            if (tick_s) begin
               if (bit_cnt_q == LAST_DATA) begin
                  bit_cnt_d = 3'd0;
                  if (HAS_PAR) begin
                     state_d = PARITY;
                     txd_d   = parity_q;
                  end else begin
                     state_d = STOP;
                     txd_d   = 1'b1;
                  end
               end else begin
                  shift_d   = shift_q >> 1;
                  txd_d     = shift_q[1];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               txd_d = shift_q[0];
            end
         end
         PARITY: begin
            if (tick_s) begin
               state_d   = STOP;
               bit_cnt_d = 3'd0;
               txd_d     = 1'b1;
            end else begin
               txd_d     = parity_q;
            end
         end
         STOP: begin
            // Registered pulse must land on the final cycle, so arm it one count early.
            if (pre_tick_s && (bit_cnt_q == LAST_STOP)) begin
               done_d = 1'b1;
            end else begin
               done_d = 1'b0;
            end
            if (tick_s) begin
               if (bit_cnt_q == LAST_STOP) begin
                  state_d   = IDLE;
                  bit_cnt_d = 3'd0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q;
            end
            txd_d = 1'b1;
         end
         default: begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            txd_d     = 1'b1;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered line outputs; reset discards any frame in flight.
   always_ff @(posedge clk_fpga) begin
      if (reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         bit_cnt_q <= 3'd0;
         txd_q     <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         bit_cnt_q <= bit_cnt_d;
         txd_q     <= txd_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign txd     = txd_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench: the driver queues hand-written frames, a monitor checks the line cycle by cycle.
module tb_uart_transmitter;

   typedef struct {
      logic [11:0] bits;
      int          nbits;
      int          bcyc;
      logic [7:0]  data;
      int          abort_at;
   } exp_t;

   logic       clk_fpga = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic [3:0] valid_v;
   logic [1:0] sel;
   logic       rdy0, rdy1, rdy2, rdy3;
   logic       txd0, txd1, txd2, txd3;
   logic       bsy0, bsy1, bsy2, bsy3;
   logic       dn0, dn1, dn2, dn3;
   logic [3:0] ready_w, txd_w, busy_w, done_w;
   logic       m_txd, m_busy, m_done, m_ready;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   frames_done = 0;
   bit   mon_active = 1'b0;
   int   starts_q[$];
   exp_t sb_q[$];

   always #5 clk_fpga = ~clk_fpga;
   always @(posedge clk_fpga) cyc <= cyc + 1;

   uart_transmitter #(.CLK_FREQ(16), .BAUD_RATE(1)) dut_8n1 (
      .clk_fpga(clk_fpga), .reset(reset), .tx_data(tx_data), .tx_valid(valid_v[0]),
      .tx_ready(rdy0), .txd(txd0), .tx_busy(bsy0), .tx_done(dn0));
   uart_transmitter #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY_EN(1), .PARITY_ODD(0)) dut_8e1 (
      .clk_fpga(clk_fpga), .reset(reset), .tx_data(tx_data), .tx_valid(valid_v[1]),
      .tx_ready(rdy1), .txd(txd1), .tx_busy(bsy1), .tx_done(dn1));
   uart_transmitter #(.CLK_FREQ(16), .BAUD_RATE(1), .PARITY_EN(1), .PARITY_ODD(1)) dut_8o1 (
      .clk_fpga(clk_fpga), .reset(reset), .tx_data(tx_data), .tx_valid(valid_v[2]),
      .tx_ready(rdy2), .txd(txd2), .tx_busy(bsy2), .tx_done(dn2));
   uart_transmitter dut_def (
      .clk_fpga(clk_fpga), .reset(reset), .tx_data(tx_data), .tx_valid(valid_v[3]),
      .tx_ready(rdy3), .txd(txd3), .tx_busy(bsy3), .tx_done(dn3));

   assign ready_w = {rdy3, rdy2, rdy1, rdy0};
   assign txd_w   = {txd3, txd2, txd1, txd0};
   assign busy_w  = {bsy3, bsy2, bsy1, bsy0};
   assign done_w  = {dn3, dn2, dn1, dn0};
   assign m_txd   = txd_w[sel];
   assign m_busy  = busy_w[sel];
   assign m_done  = done_w[sel];
   assign m_ready = ready_w[sel];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (sim cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: cycle c=1 is the first cycle after the accept edge.
   initial begin
      exp_t e;
      int   n_last, bi, ph;
      logic [7:0] rx;
      forever begin
         @(negedge clk_fpga);
         if (m_busy === 1'b1) begin
            if (sb_q.size() == 0) begin
               check("unexpected_frame", 32'd1, 32'd0);
               while (m_busy === 1'b1) @(negedge clk_fpga);
            end else begin
               mon_active = 1'b1;
               e = sb_q.pop_front();
               starts_q.push_back(cyc);
               rx = 8'h00;
               n_last = e.nbits * e.bcyc;
               for (int c = 1; c <= n_last + 1; c++) begin
                  if (c > 1) @(negedge clk_fpga);
                  if (e.abort_at != 0 && c > e.abort_at) begin
                     check("abort_txd", 32'(m_txd), 32'd1);
                     check("abort_busy", 32'(m_busy), 32'd0);
                     check("abort_done", 32'(m_done), 32'd0);
                     if (c >= e.abort_at + 2) break;
                  end else if (c <= n_last) begin
                     bi = (c - 1) / e.bcyc;
                     ph = (c - 1) % e.bcyc;
                     check("txd_bit", 32'(m_txd), 32'(e.bits[bi]));
                     check("tx_done", 32'(m_done), (c == n_last) ? 32'd1 : 32'd0);
                     check("tx_busy", 32'(m_busy), 32'd1);
                     if (ph == e.bcyc / 2 && bi >= 1 && bi <= 8) rx[bi-1] = m_txd;
                  end else begin
                     check("ready_after", 32'(m_ready), 32'd1);
                     check("busy_after", 32'(m_busy), 32'd0);
                     check("rx_data", 32'(rx), 32'(e.data));
                  end
               end
               frames_done++;
               mon_active = 1'b0;
            end
         end
      end
   end

   task automatic send(input logic [1:0] s, input logic [7:0] d, input logic [11:0] bits,
                       input int nbits, input int bcyc, input int abort_at, input bit hold);
      exp_t e;
      int   budget;
      e.bits = bits; e.nbits = nbits; e.bcyc = bcyc; e.data = d; e.abort_at = abort_at;
      @(negedge clk_fpga);
      sel = s;
      tx_data = d;
      valid_v[s] = 1'b1;
      sb_q.push_back(e);
      budget = 100000;
      while (ready_w[s] !== 1'b1 && budget > 0) begin
         @(negedge clk_fpga);
         budget--;
      end
      if (budget == 0) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk_fpga);
      @(negedge clk_fpga);
      if (!hold) valid_v[s] = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int b;
      b = budget;
      @(negedge clk_fpga);
      while ((sb_q.size() != 0 || mon_active) && b > 0) begin
         @(negedge clk_fpga);
         b--;
      end
      if (b == 0) check("idle_timeout", 32'd0, 32'd1);
      repeat (3) @(negedge clk_fpga);
   endtask

   initial begin
      reset = 1'b1;
      valid_v = 4'b0000;
      tx_data = 8'h00;
      sel = 2'd0;
      // Reset held 3 cycles; a byte offered during reset must not be taken.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_fpga);
         valid_v[0] = (i < 2);
         tx_data = 8'h77;
         if (i > 0) begin
            check("rst_txd", 32'(txd0), 32'd1);
            check("rst_busy", 32'(bsy0), 32'd0);
            check("rst_done", 32'(dn0), 32'd0);
            check("rst_ready", 32'(rdy0), 32'd0);
         end
      end
      valid_v = 4'b0000;
      reset = 1'b0;
      #1;
      check("ready_after_rst", 32'(rdy0), 32'd1);
      repeat (4) begin
         @(negedge clk_fpga);
         check("idle_txd", 32'(txd0), 32'd1);
         check("idle_busy", 32'(bsy0), 32'd0);
         check("idle_done", 32'(dn0), 32'd0);
      end

      // 8N1 0xA5: line 0,1,0,1,0,0,1,0,1,1
      send(2'd0, 8'hA5, 12'b0011_0100_1010, 10, 16, 0, 1'b0);
      wait_idle(400);

      // Back-to-back 0x00 then 0xFF with tx_valid held
      starts_q.delete();
      send(2'd0, 8'h00, 12'b0010_0000_0000, 10, 16, 0, 1'b1);
      send(2'd0, 8'hFF, 12'b0011_1111_1110, 10, 16, 0, 1'b0);
      wait_idle(600);
      if (starts_q.size() == 2) begin
         check("second_start_cycle", 32'(starts_q[1] - starts_q[0] + 1), 32'd162);
         check("stop_gap", 32'(starts_q[1] - (starts_q[0] + 144)), 32'd17);
      end else begin
         check("b2b_frame_count", 32'(starts_q.size()), 32'd2);
      end

      // Reset at cycle 70 mid-frame, then a clean 0x3C
      send(2'd0, 8'hC3, 12'b0011_1000_0110, 10, 16, 70, 1'b0);
      repeat (69) @(negedge clk_fpga);
      reset = 1'b1;
      #1;
      check("ready_in_rst", 32'(rdy0), 32'd0);
      repeat (3) @(negedge clk_fpga);
      reset = 1'b0;
      #1;
      check("ready_rst_release", 32'(rdy0), 32'd1);
      send(2'd0, 8'h3C, 12'b0010_0111_1000, 10, 16, 0, 1'b0);
      wait_idle(400);

      // 8E1 and 8O1 with 0xA5: parity bit 0 and 1 respectively
      send(2'd1, 8'hA5, 12'b0101_0100_1010, 11, 16, 0, 1'b0);
      wait_idle(400);
      send(2'd2, 8'hA5, 12'b0111_0100_1010, 11, 16, 0, 1'b0);
      wait_idle(400);

      // Defaults (5208 clocks per bit): 0x5A, done on cycle 52080
      send(2'd3, 8'h5A, 12'b0010_1011_0100, 10, 5208, 0, 1'b0);
      wait_idle(60000);

      check("frames_seen", 32'(frames_done), 32'd8);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serial UART transmitter. Frame format: 1 start bit (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1). Default is 8N1 at 9600 baud from a 50 MHz clock.
- Fed by a valid/ready byte source. Drives the txd pin.
- Same line format and clock domain as uart_receiver, so the two form a loopback pair.

Parameters:
- CLK_FREQ, 50_000_000, clk_fpga frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s.
- DATA_BITS, 8, data bits per frame. Legal range 5..8.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits. Legal values 1 or 2.

Ports:
- clk_fpga  in  1  system clock.
- reset  in  1  reset, synchronous, active-high. Clock is clk_fpga.
- tx_data  in  DATA_BITS  byte to send. Sampled only on the accept cycle.
- tx_valid  in  1  source has a byte.
- tx_ready  out  1  transmitter can accept a byte.
- txd  out  1  serial line, registered, idles high.
- tx_busy  out  1  high while a frame is on the line.
- tx_done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- BIT_CYCLES = CLK_FREQ/BAUD_RATE, integer division (5208 at defaults). Elaboration error if BIT_CYCLES < 2.
- N = 1 + DATA_BITS + PARITY_EN + STOP_BITS (10 at defaults).
- Reset values: txd=1, tx_busy=0, tx_done=0, state IDLE, all counters 0.
- tx_ready = (state==IDLE) && !reset. It is 0 during reset, so no accept can occur while reset is asserted.
- Accept: tx_valid && tx_ready at a clock edge.
  - tx_data is latched into the shift register.
  - If PARITY_EN=1, parity is computed from the latched data: XOR of the data bits, XORed with PARITY_ODD.
  - The baud counter is cleared, so the start bit is aligned to the accept.
- State machine: IDLE -> START -> DATA -> PARITY (only if PARITY_EN=1) -> STOP -> IDLE.
  - Each bit is held for exactly BIT_CYCLES clocks.
  - DATA shifts the register right once per bit. A bit counter runs 0..DATA_BITS-1.
  - STOP repeats STOP_BITS times.
- Timing, with the accept edge counted as cycle 0:
  - txd=0 during cycles 1..BIT_CYCLES.
  - The frame occupies cycles 1..N*BIT_CYCLES.
  - tx_busy=1 during cycles 1..N*BIT_CYCLES.
  - tx_done=1 only in cycle N*BIT_CYCLES.
  - tx_ready=1 from cycle N*BIT_CYCLES+1.
- Back-to-back: if tx_valid is held, the next accept happens at cycle N*BIT_CYCLES+1. The effective last stop bit is therefore BIT_CYCLES+1 clocks; no other inter-frame gap.
- tx_valid/tx_data changing mid-frame: ignored. tx_valid dropping before accept: no frame is sent.
- Reset mid-frame:
  - On the next edge, txd=1 and state=IDLE.
  - The frame is discarded and no tx_done pulse is issued.
  - tx_ready rises the first cycle reset is low.
- Counter widths:
  - Baud counter: clog2(BIT_CYCLES) bits. It wraps to 0 at BIT_CYCLES-1, never at a power of 2.
  - Bit counter: 3 bits wide.

Decomposition:
- Shared package uart_pkg:
  - state enum: IDLE, START, DATA, PARITY, STOP.
  - function bit_cycles(clk_freq, baud_rate).
  - function frame_bits(data_bits, parity_en, stop_bits).
  - The receiver reuses the same constants.
- One natural sub-module: uart_baud_tick.
  - A clear-able counter that emits a tick on its last count of BIT_CYCLES.
  - Instantiated once.
  - Shift register, parity and FSM stay in uart_transmitter.

Test Plan:
- All tests use CLK_FREQ=16, BAUD_RATE=1 (BIT_CYCLES=16) unless noted.
- Reset held 3 cycles, then released -> txd=1, tx_busy=0, tx_done=0 throughout; tx_ready=0 during reset, 1 after.
- 8N1, send 0xA5 -> txd bit sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 cycles; tx_done pulses at cycle 160 only; tx_ready returns at cycle 161.
- PARITY_EN=1, send 0xA5 -> parity bit 0 with PARITY_ODD=0 and 1 with PARITY_ODD=1; 11-bit frame; tx_done at cycle 176.
- tx_valid held high with bytes 0x00 then 0xFF -> second start bit at cycle 162; stop-to-start high gap of exactly 17 cycles; each frame's bits match its byte.
- Reset asserted at cycle 70 mid-frame -> txd=1 from cycle 71; no tx_done; the next accepted 0x3C is sent cleanly.
- Loopback at defaults (50 MHz, 9600 baud): txd wired to uart_receiver rxd, send 0x5A -> rxdata=0x5A after the frame; tx_done asserted at cycle 52080.
